reflet_timer_scheduler: RTL and testbench

Memory-mapped software-timer scheduler that shares one hardware timer among N_SLOTS independent timeout channels. The tick input is driven by a reflet timer interrupt output. Each slot down-counts on every tick and raises a pending flag on expiry. A round-robin arbiter picks which pending slot the CPU services next and drives one shared interrupt line. It sits on the 8-bit system bus beside the timers.

---
 rtl/reflet_timer_scheduler_pkg.sv | 41 ++++
 rtl/reflet_timer_sched_slot.sv | 69 ++++++
 rtl/reflet_timer_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_reflet_timer_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_timer_scheduler_pkg.sv
// reflet_timer_scheduler_pkg
// Register offsets, SCTRL bit positions and address helpers shared by
// the scheduler RTL and the firmware headers generated from it.
// Optional macro: REFLET_TIMER_SCHED_OVERRUN_EN adds the OVERRUN register
// directly after the last slot register pair.
package reflet_timer_scheduler_pkg;

    localparam logic [7:0] GCTRL_OFF   = 8'd0;
    localparam logic [7:0] PENDING_OFF = 8'd1;
    localparam logic [7:0] MASK_OFF    = 8'd2;
    localparam logic [7:0] NEXT_OFF    = 8'd3;
    localparam int         SLOT_BASE   = 4;
    localparam int         SLOT_STRIDE = 2;

    localparam int SCTRL_EN_BIT       = 0;
    localparam int SCTRL_PERIODIC_BIT = 1;
    localparam int NEXT_VALID_BIT     = 7;

    // Packed so that en lands on bit 0 and periodic on bit 1 of SCTRL.
    typedef struct packed {
        logic periodic;
        logic en;
    } sctrl_t;

    function automatic logic [7:0] reload_off(input int slot);
        return 8'(SLOT_BASE + SLOT_STRIDE * slot);
    endfunction

    function automatic logic [7:0] sctrl_off(input int slot);
        return 8'(SLOT_BASE + SLOT_STRIDE * slot + 1);
    endfunction

    function automatic int map_size(input int n_slots);
`ifdef REFLET_TIMER_SCHED_OVERRUN_EN
        return SLOT_BASE + SLOT_STRIDE * n_slots + 1;
`else
        return SLOT_BASE + SLOT_STRIDE * n_slots;
`endif
    endfunction

endpackage

// File: rtl/reflet_timer_sched_slot.sv
// reflet_timer_sched_slot
// One timeout channel: RELOAD and SCTRL registers plus the 8-bit down-counter.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   tick_event    one-cycle tick pulse, already gated by the global enable
//   wr_reload     bus write strobe for this slot's RELOAD
//   wr_sctrl      bus write strobe for this slot's SCTRL
//   data_in       bus write data
//   expire        high in the cycle the counter runs out on a tick
//   reload_rd     RELOAD read data
//   sctrl_rd      SCTRL read data (unimplemented bits 0)
module reflet_timer_sched_slot
    import reflet_timer_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_event,
    input  logic       wr_reload,
    input  logic       wr_sctrl,
    input  logic [7:0] data_in,
    output logic       expire,
    output logic [7:0] reload_rd,
    output logic [7:0] sctrl_rd
);

    logic [7:0] reload_q;
    logic [7:0] count_q;
    sctrl_t     sctrl_q;

    // A bus write to this slot swallows a coincident tick, so expiry is
    // suppressed in that cycle as well.
    assign expire = tick_event & sctrl_q.en & (count_q == 8'd1)
                    & ~wr_reload & ~wr_sctrl;

    // A zero count never reaches 1, so RELOAD=0 parks the slot at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q <= 8'd0;
            count_q  <= 8'd0;
            sctrl_q  <= '0;
        end else if (wr_reload) begin
            reload_q <= data_in;
            if (sctrl_q.en) begin
                count_q <= data_in;
            end
        end else if (wr_sctrl) begin
            sctrl_q.en       <= data_in[SCTRL_EN_BIT];
            sctrl_q.periodic <= data_in[SCTRL_PERIODIC_BIT];
            if (!sctrl_q.en && data_in[SCTRL_EN_BIT]) begin
                count_q <= reload_q;
            end
        end else if (tick_event && sctrl_q.en) begin
            if (count_q == 8'd1) begin
                if (sctrl_q.periodic) begin
                    count_q <= reload_q;
                end else begin
                    count_q    <= 8'd0;
                    sctrl_q.en <= 1'b0;
                end
            end else if (count_q != 8'd0) begin
                count_q <= count_q - 8'd1;
            end
        end
    end

    assign reload_rd = reload_q;
    assign sctrl_rd  = {6'b0, sctrl_q};

endmodule

// File: rtl/reflet_timer_scheduler.sv
// reflet_timer_scheduler
// Shares one hardware timer tick among N_SLOTS software timeouts, tracks
// which have expired in PENDING, and presents a round-robin NEXT pointer
// plus one shared interrupt to the CPU over the 8-bit system bus.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   enable       bus enable
//   addr         bus address
//   write_en     bus write strobe
//   data_in      bus write data
//   data_out     combinational read data, 0 when not addressed
//   tick         timebase from the timer interrupt (rising-edge detected)
//   interrupt    GCTRL.en & |(PENDING & MASK)
// Optional macro: REFLET_TIMER_SCHED_OVERRUN_EN (OVERRUN register).
module reflet_timer_scheduler
    import reflet_timer_scheduler_pkg::*;
#(
    parameter int                       base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF20,
    parameter int                       N_SLOTS        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      tick,
    output logic                      interrupt
);

    localparam int                        MAP_SIZE  = map_size(N_SLOTS);
    localparam logic [base_addr_size-1:0] MAP_LIMIT = base_addr_size'(MAP_SIZE);

    logic [base_addr_size-1:0] offset;
    logic [7:0]                reg_off;
    logic                      hit;
    logic                      bus_wr;

    logic               tick_r;
    logic               tick_d;
    logic               tick_event;
    logic               gctrl_en;
    logic [N_SLOTS-1:0] pending;
    logic [N_SLOTS-1:0] mask_q;
    logic [N_SLOTS-1:0] clear_vec;
    logic [N_SLOTS-1:0] expire_vec;
    logic [N_SLOTS-1:0] wr_reload_vec;
    logic [N_SLOTS-1:0] wr_sctrl_vec;
    logic [7:0]         reload_rd [N_SLOTS];
    logic [7:0]         sctrl_rd  [N_SLOTS];
    logic [7:0]         masked8;
    logic [2:0]         rr_ptr;
    logic [2:0]         next_idx;
    logic               next_valid;
    int                 scan_pos;

    // Unsigned subtraction wraps below base_addr, so the lower-bound test
    // must stay explicit.
    assign offset  = addr - base_addr;
    assign hit     = enable && (addr >= base_addr) && (offset < MAP_LIMIT);
    assign reg_off = offset[7:0];
    assign bus_wr  = hit & write_en;

    assign clear_vec = (bus_wr && reg_off == PENDING_OFF) ? data_in[N_SLOTS-1:0] : '0;

    // Tick is synchronised by one flop, then its rising edge is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_r <= 1'b0;
            tick_d <= 1'b0;
        end else begin
            tick_r <= tick;
            tick_d <= tick_r;
        end
    end

    assign tick_event = tick_r & ~tick_d & gctrl_en;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        assign wr_reload_vec[i] = bus_wr && (reg_off == reload_off(i));
        assign wr_sctrl_vec[i]  = bus_wr && (reg_off == sctrl_off(i));

        reflet_timer_sched_slot u_slot (
            .clk        (clk),
            .reset      (reset),
            .tick_event (tick_event),
            .wr_reload  (wr_reload_vec[i]),
            .wr_sctrl   (wr_sctrl_vec[i]),
            .data_in    (data_in),
            .expire     (expire_vec[i]),
            .reload_rd  (reload_rd[i]),
            .sctrl_rd   (sctrl_rd[i])
        );
    end

    // Setting has priority over a same-cycle W1C, hence OR after the clear.
    // The RR pointer only moves when the CPU acknowledges the slot shown in NEXT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gctrl_en <= 1'b0;
            pending  <= '0;
            mask_q   <= '0;
            rr_ptr   <= 3'd0;
        end else begin
            if (bus_wr && reg_off == GCTRL_OFF) begin
                gctrl_en <= data_in[0];
            end
            if (bus_wr && reg_off == MASK_OFF) begin
                mask_q <= data_in[N_SLOTS-1:0];
            end
            pending <= (pending & ~clear_vec) | expire_vec;
            if (bus_wr && reg_off == PENDING_OFF && next_valid && data_in[next_idx]) begin
                rr_ptr <= (next_idx == 3'(N_SLOTS - 1)) ? 3'd0 : next_idx + 3'd1;
            end
        end
    end

    assign interrupt = gctrl_en & |(pending & mask_q);

    // Scan downward so the last hit written is the closest one at or after
    // rr_ptr, which gives the upward-with-wrap priority.
    assign masked8 = 8'(pending & mask_q);

    always_comb begin
        next_valid = 1'b0;
        next_idx   = 3'd0;
        scan_pos   = 0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            scan_pos = int'(rr_ptr) + k;
            if (scan_pos >= N_SLOTS) begin
                scan_pos = scan_pos - N_SLOTS;
            end
            if (masked8[3'(scan_pos)]) begin
                next_valid = 1'b1;
                next_idx   = 3'(scan_pos);
            end
        end
    end

`ifdef REFLET_TIMER_SCHED_OVERRUN_EN
    localparam logic [7:0] OVERRUN_OFF = 8'(MAP_SIZE - 1);

    logic [N_SLOTS-1:0] overrun_q;

    // An expiry landing on an already-pending slot means a timeout was lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= (overrun_q
                          & ~((bus_wr && reg_off == OVERRUN_OFF) ? data_in[N_SLOTS-1:0] : '0))
                         | (expire_vec & pending);
        end
    end
`endif

    always_comb begin
        data_out = 8'h00;
        if (hit) begin
            case (reg_off)
                GCTRL_OFF:   data_out = {7'b0, gctrl_en};
                PENDING_OFF: data_out = 8'(pending);
                MASK_OFF:    data_out = 8'(mask_q);
                NEXT_OFF: begin
                    data_out                 = {5'b0, next_idx};
                    data_out[NEXT_VALID_BIT] = next_valid;
                end
                default: ;
            endcase
            for (int i = 0; i < N_SLOTS; i++) begin
                if (reg_off == reload_off(i)) begin
                    data_out = reload_rd[i];
                end
                if (reg_off == sctrl_off(i)) begin
                    data_out = sctrl_rd[i];
                end
            end
`ifdef REFLET_TIMER_SCHED_OVERRUN_EN
            if (reg_off == OVERRUN_OFF) begin
                data_out = 8'(overrun_q);
            end
`endif
        end
    end

endmodule

// File: tb/tb_reflet_timer_scheduler.sv
// tb_reflet_timer_scheduler
// Bench for reflet_timer_scheduler: a transaction-level model of the
// register file and timeouts is compared against data_out and interrupt on
// every falling edge, and directed scenarios pin literal values.
// Honours REFLET_TIMER_SCHED_OVERRUN_EN the same way the design does.
module tb_reflet_timer_scheduler;

    localparam int          N       = 4;
    localparam logic [15:0] BASE    = 16'hFF20;
    localparam logic [15:0] A_GCTRL = 16'hFF20;
    localparam logic [15:0] A_PEND  = 16'hFF21;
    localparam logic [15:0] A_MASK  = 16'hFF22;
    localparam logic [15:0] A_NEXT  = 16'hFF23;
    localparam logic [15:0] A_RLD0  = 16'hFF24;
    localparam logic [15:0] A_SC0   = 16'hFF25;
    localparam logic [15:0] A_RLD1  = 16'hFF26;
    localparam logic [15:0] A_SC1   = 16'hFF27;
    localparam logic [15:0] A_RLD2  = 16'hFF28;
    localparam logic [15:0] A_SC2   = 16'hFF29;
    localparam logic [15:0] A_OVR   = 16'hFF2C;
`ifdef REFLET_TIMER_SCHED_OVERRUN_EN
    localparam int         MAP     = 5 + 2 * N;
    localparam logic [7:0] OVR_EXP = 8'h01;
`else
    localparam int         MAP     = 4 + 2 * N;
    localparam logic [7:0] OVR_EXP = 8'h00;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic        write_en = 1'b0;
    logic        tick     = 1'b0;
    logic [15:0] addr     = BASE;
    logic [7:0]  data_in  = 8'h00;
    logic [7:0]  data_out;
    logic        interrupt;

    int n_assert = 0;
    int n_fail   = 0;
    int expiries = 0;

    // Model state: what software would see in each register.
    int       m_reload [N];
    int       m_cnt    [N];
    bit       m_en     [N];
    bit       m_per    [N];
    bit [7:0] m_pending;
    bit [7:0] m_mask;
    bit [7:0] m_ovr;
    bit       m_gen;
    int       m_rr;

    reflet_timer_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .write_en  (write_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .tick      (tick),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_reload[i] = 0;
            m_cnt[i]    = 0;
            m_en[i]     = 1'b0;
            m_per[i]    = 1'b0;
        end
        m_pending = 8'h00;
        m_mask    = 8'h00;
        m_ovr     = 8'h00;
        m_gen     = 1'b0;
        m_rr      = 0;
    endtask

    // Returns the slot NEXT should show, or -1 when none is masked-pending.
    function automatic int modelNext();
        for (int k = 0; k < N; k++) begin
            if (m_pending[(m_rr + k) % N] && m_mask[(m_rr + k) % N]) begin
                return (m_rr + k) % N;
            end
        end
        return -1;
    endfunction

    function automatic logic [7:0] modelRead();
        int off;
        int nx;
        int s;
        if (!enable) return 8'h00;
        off = int'(addr) - int'(BASE);
        if (off < 0 || off >= MAP) return 8'h00;
        if (off == 0) return {7'b0, m_gen};
        if (off == 1) return m_pending;
        if (off == 2) return m_mask;
        if (off == 3) begin
            nx = modelNext();
            return (nx < 0) ? 8'h00 : 8'(8'h80 + nx);
        end
        if (off < 4 + 2 * N) begin
            s = (off - 4) / 2;
            if ((off - 4) % 2 == 0) return 8'(m_reload[s]);
            return {6'b0, m_per[s], m_en[s]};
        end
        return m_ovr;
    endfunction

    function automatic bit modelIrq();
        return m_gen && ((m_pending & m_mask) != 8'h00);
    endfunction

    task automatic modelWrite(input logic [15:0] a, input logic [7:0] d);
        int off;
        int nx;
        int s;
        off = int'(a) - int'(BASE);
        if (off >= 0 && off < MAP) begin
            if (off == 0) m_gen = d[0];
            else if (off == 1) begin
                nx = modelNext();
                if (nx >= 0 && d[nx]) m_rr = (nx + 1) % N;
                m_pending = m_pending & ~(d & 8'h0F);
            end
            else if (off == 2) m_mask = d & 8'h0F;
            else if (off == 3) begin end
            else if (off < 4 + 2 * N) begin
                s = (off - 4) / 2;
                if ((off - 4) % 2 == 0) begin
                    m_reload[s] = int'(d);
                    if (m_en[s]) m_cnt[s] = int'(d);
                end else begin
                    if (!m_en[s] && d[0]) m_cnt[s] = m_reload[s];
                    m_en[s]  = d[0];
                    m_per[s] = d[1];
                end
            end
            else m_ovr = m_ovr & ~(d & 8'h0F);
        end
    endtask

    // One timebase tick; skip names a slot whose register is being written.
    task automatic modelTick(input int skip);
        if (m_gen) begin
            for (int i = 0; i < N; i++) begin
                if (i != skip && m_en[i]) begin
                    if (m_cnt[i] == 1) begin
                        if (m_pending[i]) m_ovr[i] = 1'b1;
                        m_pending[i] = 1'b1;
                        if (m_per[i]) m_cnt[i] = m_reload[i];
                        else begin
                            m_en[i]  = 1'b0;
                            m_cnt[i] = 0;
                        end
                    end else if (m_cnt[i] > 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_assert++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic w, input logic [15:0] a, input logic [7:0] d);
        enable   = e;
        write_en = w;
        addr     = a;
        data_in  = d;
    endtask

    task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b1, a, d);
        @(posedge clk);
        modelWrite(a, d);
        #1 applyStimulus(1'b1, 1'b0, A_PEND, 8'h00);
    endtask

    task automatic busRead(input logic e, input logic [15:0] a, input logic [7:0] exp, input string name);
        @(posedge clk);
        #1 applyStimulus(e, 1'b0, a, 8'h00);
        @(negedge clk);
        checkOutput(name, data_out, exp);
    endtask

    // Tick rises, is registered at the next edge, and counters move one
    // edge later.
    task automatic tickPulse();
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, A_PEND, 8'h00);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(posedge clk);
        modelTick(-1);
    endtask

    task automatic tickWithWrite(input logic [15:0] a, input logic [7:0] d, input int slot);
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        applyStimulus(1'b1, 1'b1, a, d);
        @(posedge clk);
        modelTick(slot);
        modelWrite(a, d);
        #1 applyStimulus(1'b1, 1'b0, A_PEND, 8'h00);
    endtask

    // Continuous comparison of the DUT against the model.
    always @(negedge clk) begin
        checkOutput("cyc_irq", {7'b0, interrupt}, {7'b0, modelIrq()});
        checkOutput("cyc_data", data_out, modelRead());
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        modelReset();
        #12 reset = 1'b0;

        $display("[TB] reset state");
        busRead(1'b1, A_GCTRL, 8'h00, "rst_gctrl");
        busRead(1'b1, A_PEND,  8'h00, "rst_pending");
        busRead(1'b1, A_NEXT,  8'h00, "rst_next");
        checkOutput("rst_irq", {7'b0, interrupt}, 8'h00);

        $display("[TB] one-shot slot 0");
        busWrite(A_GCTRL, 8'h01);
        busWrite(A_MASK,  8'h01);
        busWrite(A_RLD0,  8'h03);
        busWrite(A_SC0,   8'h01);
        tickPulse();
        tickPulse();
        busRead(1'b1, A_PEND, 8'h00, "t1_pend_after2");
        tickPulse();
        busRead(1'b1, A_PEND, 8'h01, "t1_pend_after3");
        checkOutput("t1_irq", {7'b0, interrupt}, 8'h01);
        busRead(1'b1, A_SC0,  8'h00, "t1_sctrl0");
        busRead(1'b1, A_NEXT, 8'h80, "t1_next");
        busWrite(A_PEND, 8'h01);
        busRead(1'b1, A_NEXT, 8'h00, "t1_next_clr");

        $display("[TB] periodic slot 1");
        busWrite(A_MASK, 8'h03);
        busWrite(A_SC1,  8'h03);
        busWrite(A_RLD1, 8'h02);
        for (int t = 0; t < 6; t++) begin
            tickPulse();
            @(negedge clk);
            checkOutput($sformatf("t2_pend1_tick%0d", t), {7'b0, data_out[1]},
                        (t % 2 == 1) ? 8'h01 : 8'h00);
            if (data_out[1]) begin
                expiries++;
                busWrite(A_PEND, 8'h02);
            end
        end
        checkOutput("t2_expiries", 8'(expiries), 8'd3);
        busRead(1'b1, A_SC1, 8'h03, "t2_sctrl1");

        $display("[TB] round robin");
        @(posedge clk);
        #2 reset = 1'b1;
        modelReset();
        @(posedge clk);
        #2 reset = 1'b0;
        busWrite(A_GCTRL, 8'h01);
        busWrite(A_MASK,  8'h05);
        busWrite(A_RLD0,  8'h01);
        busWrite(A_RLD2,  8'h01);
        busWrite(A_SC0,   8'h01);
        busWrite(A_SC2,   8'h01);
        tickPulse();
        busRead(1'b1, A_PEND, 8'h05, "t3_pend");
        busRead(1'b1, A_NEXT, 8'h80, "t3_next0");
        busWrite(A_PEND, 8'h01);
        busRead(1'b1, A_NEXT, 8'h82, "t3_next2");
        busWrite(A_SC0, 8'h01);
        tickPulse();
        busRead(1'b1, A_NEXT, 8'h82, "t3_next2_again");
        busWrite(A_PEND, 8'h04);
        busRead(1'b1, A_NEXT, 8'h80, "t3_next_wrap");

        $display("[TB] write versus tick");
        busWrite(A_PEND, 8'h01);
        busWrite(A_MASK, 8'h03);
        busWrite(A_RLD0, 8'h04);
        busWrite(A_SC0,  8'h01);
        busWrite(A_RLD1, 8'h03);
        busWrite(A_SC1,  8'h01);
        tickPulse();
        tickWithWrite(A_RLD0, 8'h05, 0);
        busRead(1'b1, A_RLD0, 8'h05, "t4_reload0");
        tickPulse();
        busRead(1'b1, A_PEND, 8'h02, "t4_slot1_expired");
        tickPulse();
        tickPulse();
        tickPulse();
        busRead(1'b1, A_PEND, 8'h02, "t4_slot0_held");
        tickPulse();
        busRead(1'b1, A_PEND, 8'h03, "t4_slot0_expired");

        $display("[TB] reset mid-count");
        busWrite(A_SC0, 8'h01);
        tickPulse();
        tickPulse();
        tickPulse();
        busRead(1'b1, A_PEND, 8'h03, "t5_pend_before");
        checkOutput("t5_irq_before", {7'b0, interrupt}, 8'h01);
        @(posedge clk);
        #3 reset = 1'b1;
        modelReset();
        #1 checkOutput("t5_irq_in_reset", {7'b0, interrupt}, 8'h00);
        for (int a = 0; a < MAP; a++) begin
            applyStimulus(1'b1, 1'b0, BASE + 16'(a), 8'h00);
            #1 checkOutput($sformatf("t5_reg%0d", a), data_out, 8'h00);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        tickPulse();
        tickPulse();
        busRead(1'b1, A_PEND, 8'h00, "t5_no_expiry");
        busWrite(A_RLD0, 8'h01);
        busWrite(A_SC0,  8'h01);
        tickPulse();
        busRead(1'b1, A_PEND, 8'h00, "t5_gctrl_off_hold");
        busWrite(A_GCTRL, 8'h01);
        tickPulse();
        busRead(1'b1, A_PEND, 8'h01, "t5_gctrl_on_expire");
        busWrite(A_PEND, 8'h01);

        $display("[TB] overrun");
        busWrite(A_SC0, 8'h03);
        tickPulse();
        tickPulse();
        busRead(1'b1, A_OVR, OVR_EXP, "t6_overrun_set");
        busWrite(A_OVR, 8'h01);
        busRead(1'b1, A_OVR, 8'h00, "t6_overrun_clr");
        busWrite(A_SC0, 8'h00);

        $display("[TB] decode boundaries");
        busRead(1'b0, A_GCTRL, 8'h00, "dec_disabled");
        busRead(1'b1, 16'hFF1F, 8'h00, "dec_below");
        busRead(1'b1, BASE + 16'(MAP), 8'h00, "dec_above");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
